// File: rtl/dlf_div_seq.sv
// Sequential DLFloat divider.
// Special operands bypass the datapath. Normal operands run a radix-2 restoring
// mantissa iteration, then one rounding step (RNE or truncate). Both sides use
// valid/ready handshakes.
module dlf_div_seq #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int Q_BITS = MAN_W + 3;
  localparam int RW     = MAN_W + 2;
  localparam int EW     = EXP_W + 2;
  localparam int CW     = $clog2(Q_BITS + 1);
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE   = EW'(1);
  localparam logic signed [EW-1:0] ZERO  = EW'(0);
  localparam logic [CW-1:0]        LAST  = CW'(Q_BITS - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [Q_BITS-1:0]       quo_q, quo_d;
  logic [MAN_W:0]          mb_q, mb_d;
  logic signed [EW-1:0]    exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic                    rnd_q, rnd_d;
  logic                    out_valid_q, out_valid_d;
  logic [W-1:0]            result_q, result_d;
  logic [4:0]              flags_q, flags_d;

  // Operand field decode
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, in_sign, in_special;
  logic signed [EW-1:0] exp_in;

  assign a_exp      = a[W-2:MAN_W];
  assign b_exp      = b[W-2:MAN_W];
  assign a_frac     = a[MAN_W-1:0];
  assign b_frac     = b[MAN_W-1:0];
  assign a_zero     = (a_exp == '0);
  assign b_zero     = (b_exp == '0);
  assign a_inf      = (&a_exp) && (a_frac == '0);
  assign b_inf      = (&b_exp) && (b_frac == '0);
  assign a_nan      = (&a_exp) && (&a_frac);
  assign b_nan      = (&b_exp) && (&b_frac);
  assign in_sign    = a[W-1] ^ b[W-1];
  assign in_special = a_nan | b_nan | a_zero | b_zero | a_inf | b_inf;
  assign exp_in     = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;

  // One restoring step: subtract the divisor when it fits, then shift
  logic          div_ge;
  logic [RW-1:0] rem_sub;
  assign div_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = div_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Special-case result selection in priority order
  logic [W-1:0] spec_res;
  logic [4:0]   spec_flg;
  always_comb begin
    spec_res = {in_sign, {(W-1){1'b0}}};
    spec_flg = 5'b00000;
    if (a_nan || b_nan) begin
      spec_res = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      spec_flg = 5'b10000;
    end else if (b_zero && !a_inf) begin
      spec_res = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flg = 5'b01000;
    end else if (a_inf) begin
      spec_res = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Normalise, round and range-check the finished quotient
  logic                 norm, guard, sticky, inc, nx;
  logic [MAN_W-1:0]     frac_t;
  logic [MAN_W:0]       frac_inc;
  logic signed [EW-1:0] exp_t, exp_r;
  logic [W-1:0]         rnd_res;
  logic [4:0]           rnd_flg;
  always_comb begin
    norm = quo_q[Q_BITS-1];
    if (norm) begin
      frac_t = quo_q[MAN_W+1:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != '0);
      exp_t  = exp_q;
    end else begin
      frac_t = quo_q[MAN_W:1];
      guard  = quo_q[0];
      sticky = (rem_q != '0);
      exp_t  = exp_q - ONE;
    end
    inc      = ~rnd_q & guard & (sticky | frac_t[0]);
    frac_inc = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    exp_r    = frac_inc[MAN_W] ? (exp_t + ONE) : exp_t;
    nx       = guard | sticky;
    if (exp_r >= EMAX) begin
      rnd_res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      rnd_flg = 5'b00101;
    end else if (exp_r <= ZERO) begin
      rnd_res = {sign_q, {(W-1){1'b0}}};
      rnd_flg = 5'b00011;
    end else begin
      rnd_res = {sign_q, exp_r[EXP_W-1:0], frac_inc[MAN_W-1:0]};
      rnd_flg = {4'b0000, nx};
    end
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    mb_d        = mb_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          rnd_d  = rnd_mode;
          mb_d   = {1'b1, b_frac};
          rem_d  = {2'b01, a_frac};
          quo_d  = '0;
          cnt_d  = '0;
          exp_d  = exp_in;
          if (in_special) begin
            result_d = spec_res;
            flags_d  = spec_flg;
            state_d  = DONE;
          end else begin
            state_d  = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d = {rem_sub[RW-2:0], 1'b0};
        quo_d = {quo_q[Q_BITS-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ROUND;
      end
      ROUND: begin
        result_d = rnd_res;
        flags_d  = rnd_flg;
        state_d  = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      mb_q        <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      rnd_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      mb_q        <= mb_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_dlf_div_seq.sv
// Directed bench for dlf_div_seq at DLFloat16 defaults: table of vectors with
// hand-computed results, plus backpressure and mid-operation reset sequences.
module tb_dlf_div_seq;
  logic        clk, rst_n, in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [4:0]  flags;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vr;
    logic [15:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  dlf_div_seq #(.EXP_W(6), .MAN_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design wedges in a way the bounded waits miss
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Present one operand pair, then scramble inputs and count edges to out_valid
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vr,
                               input string tag, output int lat);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = va; b = vb; rnd_mode = vr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~va; b = ~vb; rnd_mode = ~vr;
    lat = 0;
    while (lat < 40 && !out_valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Accept the result for one edge and confirm the block returns to idle
  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready_rise"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   lat;
    logic stable;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; rnd_mode = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = '{16'h4100, 16'h4000, 1'b0, 16'h3F00, 5'b00000, 14};
    vecs[1]  = '{16'h3E00, 16'h4100, 1'b0, 16'h3AAB, 5'b00001, 14};
    vecs[2]  = '{16'h3E00, 16'h4100, 1'b1, 16'h3AAA, 5'b00001, 14};
    vecs[3]  = '{16'h4000, 16'h0000, 1'b0, 16'h7E00, 5'b01000, 1};
    vecs[4]  = '{16'h0000, 16'h0000, 1'b0, 16'h7FFF, 5'b10000, 1};
    vecs[5]  = '{16'h7E00, 16'hFE00, 1'b0, 16'hFFFF, 5'b10000, 1};
    vecs[6]  = '{16'h4000, 16'h7E00, 1'b0, 16'h0000, 5'b00000, 1};
    vecs[7]  = '{16'h7DFF, 16'h0200, 1'b0, 16'h7DFF, 5'b00101, 14};
    vecs[8]  = '{16'h0200, 16'h4000, 1'b0, 16'h0000, 5'b00011, 14};
    vecs[9]  = '{16'h7FFF, 16'h4000, 1'b0, 16'h7FFF, 5'b00000, 1};
    vecs[10] = '{16'h7E00, 16'hC000, 1'b0, 16'hFE00, 5'b00000, 1};
    vecs[11] = '{16'h8000, 16'h4000, 1'b0, 16'h8000, 5'b00000, 1};
    vecs[12] = '{16'hC100, 16'h4000, 1'b0, 16'hBF00, 5'b00000, 14};
    vecs[13] = '{16'h7E00, 16'h0000, 1'b0, 16'h7E00, 5'b00000, 1};
    vecs[14] = '{16'h4000, 16'h3E00, 1'b0, 16'h4000, 5'b00000, 14};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vr, $sformatf("v%0d", i), lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      checkOutput($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flg));
      handoff($sformatf("v%0d", i));
    end

    // Backpressure: hold the result 20 cycles while a new operand waits
    applyStimulus(16'h4100, 16'h4000, 1'b0, "bp", lat);
    checkOutput("bp_latency", 32'(lat), 32'd14);
    in_valid = 1'b1; a = 16'h4000; b = 16'h0000; rnd_mode = 1'b0;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (result !== 16'h3F00 || flags !== 5'b00000 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    checkOutput("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_handoff_ovalid", 32'(out_valid), 32'd0);
    checkOutput("bp_handoff_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_next_accepted", 32'(in_ready), 32'd0);
    checkOutput("bp_next_ovalid_low", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_next_ovalid", 32'(out_valid), 32'd1);
    checkOutput("bp_next_result", 32'(result), 32'h7E00);
    checkOutput("bp_next_flags", 32'(flags), 32'b01000);
    handoff("bp_next");

    // Reset in the middle of a divide discards it immediately
    @(negedge clk);
    in_valid = 1'b1; a = 16'h3E00; b = 16'h4100; rnd_mode = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_result", 32'(result), 32'd0);
    checkOutput("mid_rst_flags", 32'(flags), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stable = 1'b0;
    end
    checkOutput("mid_rst_no_output", 32'(stable), 32'd1);
    applyStimulus(16'h4100, 16'h4000, 1'b0, "post_rst", lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd14);
    checkOutput("post_rst_result", 32'(result), 32'h3F00);
    checkOutput("post_rst_flags", 32'(flags), 32'd0);
    handoff("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
